aurora_link_sequencer: RTL and testbench
========================================

Name: aurora_link_sequencer

Overview:
- Bring-up and supervision stage directly upstream of the Aurora C2C slave core in the VU13P top.
- Drives the core's pma_init and reset_pb in the mandated order and waits for channel_up and all lane_up.
- Retries on timeout; re-sequences on link drop or hard error.
- Exports link_ok, error counters and state for the C2C bridge reset and for debug.

Parameters:
- NUM_LANES, 2, width of lane_up; matches the 2-lane slave link.
- PMA_INIT_CYCLES, 1024, sysclk cycles with pma_init and reset_pb both high.
- RESET_PB_CYCLES, 256, sysclk cycles with pma_init low and reset_pb still high.
- UP_TIMEOUT_CYCLES, 1000000, maximum wait for link up before a retry.
- STABLE_CYCLES, 64, consecutive cycles channel_up and all lane_up must hold before link_ok.
- CNT_W, 16, width of the saturating counters.

Ports:
- sysclk  in  1  free-running init/system clock, the single clock of the block.
- reset  in  1  asynchronous, active-high reset.
- link_en  in  1  enables sequencing; low forces ASSERT_PMA and holds it there.
- channel_up  in  1  from core (user_clk domain); 2-FF synchronised internally.
- lane_up  in  NUM_LANES  from core; each bit 2-FF synchronised.
- hard_err  in  1  from core; 2-FF synchronised, level-sensitive.
- soft_err  in  1  from core; 2-FF synchronised, rising-edge counted.
- pma_init  out  1  to core PMA init.
- reset_pb  out  1  to core reset_pb.
- link_ok  out  1  link up and stable; gates the C2C bridge reset.
- retry_cnt  out  CNT_W  timeouts since reset, saturating.
- drop_cnt  out  CNT_W  link losses from LINK_UP, saturating.
- soft_err_cnt  out  CNT_W  soft error rising edges while in LINK_UP, saturating.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset values: pma_init=1, reset_pb=1, link_ok=0, all counters 0, state=ASSERT_PMA, synchronisers 0, phase counter 0.
- All outputs are registered, and each state's outputs apply in the same cycle as that state.
- ASSERT_PMA (0): pma_init=1, reset_pb=1. Leaves after exactly PMA_INIT_CYCLES cycles, and only if link_en=1; otherwise the phase counter holds at 0.
- RELEASE_PMA (1): pma_init=0, reset_pb=1. Goes to WAIT_UP after RESET_PB_CYCLES cycles.
- WAIT_UP (2): pma_init=0, reset_pb=0.
  - up_all = synced channel_up AND all synced lane_up bits.
  - The stable counter increments while up_all=1 and clears when up_all=0.
  - When the stable counter reaches STABLE_CYCLES, go to LINK_UP.
  - If the timeout counter reaches UP_TIMEOUT_CYCLES first, retry_cnt++ and go to ASSERT_PMA.
  - If both conditions hit in the same cycle, LINK_UP wins.
- LINK_UP (3): link_ok=1, asserted starting the first cycle in LINK_UP.
  - up_all=0 or synced hard_err=1: drop_cnt++, link_ok=0 next cycle, go to ASSERT_PMA.
  - hard_err together with a channel drop in the same cycle counts as one drop.
- Any state with link_en=0: go to ASSERT_PMA next cycle. No counter increments, except that a LINK_UP exit counts as a drop.
- Every entry to ASSERT_PMA clears the phase, timeout and stable counters.
- Counters saturate at 2^CNT_W-1 and never wrap.
- soft_err_cnt increments once per rising edge of synced soft_err, only while in LINK_UP.
- Asynchronous reset mid-sequence returns all outputs to reset values immediately, including pma_init=1.
- Input-to-state latency: 2 synchroniser cycles plus 1 registered decision cycle.

Decomposition:
- Package aurora_seq_pkg holds:
  - the state enum (ASSERT_PMA=0, RELEASE_PMA=1, WAIT_UP=2, LINK_UP=3);
  - the counter-width constant;
  - a saturating-increment function.
- Sub-module sync_2ff, parameterised on width, used for channel_up, lane_up, hard_err and soft_err.

Test Plan:
(All scenarios use PMA_INIT_CYCLES=8, RESET_PB_CYCLES=4, UP_TIMEOUT_CYCLES=50, STABLE_CYCLES=5.)
- Nominal bring-up: link_en=1; channel_up and lane_up=2'b11 rise 10 cycles into WAIT_UP. Expect pma_init low after 8 cycles, reset_pb low 4 cycles later, link_ok high 5+2 cycles after the inputs rise, retry_cnt=0.
- Timeout: lane_up=2'b01 forever. Expect retry every 8+4+50 cycles, retry_cnt=3 after 3 periods, link_ok never 1.
- Drop: from LINK_UP, pulse channel_up low for 1 cycle. Expect drop_cnt=1, link_ok=0, pma_init=1, then full re-sequence back to link_ok.
- Flicker: up_all toggles every 3 cycles in WAIT_UP. Expect the stable counter never reaches 5, no LINK_UP, retry_cnt increments at timeout.
- Errors: in LINK_UP, 3 soft_err pulses give soft_err_cnt=3 and link_ok stays 1. Then hard_err with channel_up simultaneously low gives drop_cnt incremented by exactly 1.
- Reset and enable: assert reset mid WAIT_UP; expect pma_init=1, reset_pb=1, counters 0 asynchronously. Hold link_en=0 for 100 cycles; expect the block stays in ASSERT_PMA.

Source files
------------

// File: rtl/aurora_seq_pkg.sv
// Shared types and helpers for the Aurora link bring-up sequencer.
package aurora_seq_pkg;

  localparam int SEQ_CNT_W = 16;

  typedef enum logic [2:0] {
    ASSERT_PMA  = 3'd0,
    RELEASE_PMA = 3'd1,
    WAIT_UP     = 3'd2,
    LINK_UP     = 3'd3
  } seq_state_t;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bank for quasi-static inputs from the core's user_clk domain.
// Latency 2 clk cycles; no flow control.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aurora_link_sequencer.sv
// Sequences pma_init/reset_pb for the Aurora C2C slave core and supervises the link.
// Input-to-state latency 2 sync cycles + 1 decision cycle; outputs registered, no backpressure.
module aurora_link_sequencer
  import aurora_seq_pkg::*;
#(
  parameter int NUM_LANES         = 2,
  parameter int PMA_INIT_CYCLES   = 1024,
  parameter int RESET_PB_CYCLES   = 256,
  parameter int UP_TIMEOUT_CYCLES = 1000000,
  parameter int STABLE_CYCLES     = 64,
  parameter int CNT_W             = SEQ_CNT_W
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 link_en,
  input  logic                 channel_up,
  input  logic [NUM_LANES-1:0] lane_up,
  input  logic                 hard_err,
  input  logic                 soft_err,
  output logic                 pma_init,
  output logic                 reset_pb,
  output logic                 link_ok,
  output logic [CNT_W-1:0]     retry_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     soft_err_cnt,
  output logic [2:0]           state_o
);

  localparam int PH_MAX = (PMA_INIT_CYCLES > RESET_PB_CYCLES) ? PMA_INIT_CYCLES : RESET_PB_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TMO_W  = $clog2(UP_TIMEOUT_CYCLES + 1);
  localparam int ST_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << CNT_W) - 64'd1);

  seq_state_t           state, next_state;
  logic [PH_W-1:0]      phase_cnt;
  logic [TMO_W-1:0]     tmo_cnt, tmo_next;
  logic [ST_W-1:0]      stable_cnt, stable_next;
  logic                 retry_inc, drop_inc;
  logic                 ch_s, hard_s, soft_s, soft_d;
  logic [NUM_LANES-1:0] lane_s;
  logic                 up_all;

  sync_2ff #(.WIDTH(3)) u_sync_ctl (
    .clk (sysclk),
    .rst (reset),
    .d   ({channel_up, hard_err, soft_err}),
    .q   ({ch_s, hard_s, soft_s})
  );

  sync_2ff #(.WIDTH(NUM_LANES)) u_sync_lane (
    .clk (sysclk),
    .rst (reset),
    .d   (lane_up),
    .q   (lane_s)
  );

  assign up_all  = ch_s & (&lane_s);
  assign state_o = state;

  always_comb begin
    next_state  = state;
    tmo_next    = '0;
    stable_next = '0;
    retry_inc   = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      ASSERT_PMA: begin
        if (link_en && phase_cnt == PH_W'(PMA_INIT_CYCLES - 1)) next_state = RELEASE_PMA;
      end
      RELEASE_PMA: begin
        if (phase_cnt == PH_W'(RESET_PB_CYCLES - 1)) next_state = WAIT_UP;
      end
      WAIT_UP: begin
        tmo_next    = tmo_cnt + TMO_W'(1);
        stable_next = up_all ? stable_cnt + ST_W'(1) : '0;
        // A link that becomes stable on the timeout cycle is kept.
        if (stable_next == ST_W'(STABLE_CYCLES)) begin
          next_state = LINK_UP;
        end else if (tmo_next == TMO_W'(UP_TIMEOUT_CYCLES)) begin
          next_state = ASSERT_PMA;
          retry_inc  = 1'b1;
        end
      end
      LINK_UP: begin
        if (!up_all || hard_s) begin
          next_state = ASSERT_PMA;
          drop_inc   = 1'b1;
        end
      end
      default: next_state = ASSERT_PMA;
    endcase
    if (!link_en) begin
      next_state = ASSERT_PMA;
      retry_inc  = 1'b0;
      drop_inc   = (state == LINK_UP);
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state        <= ASSERT_PMA;
      phase_cnt    <= '0;
      tmo_cnt      <= '0;
      stable_cnt   <= '0;
      soft_d       <= 1'b0;
      retry_cnt    <= '0;
      drop_cnt     <= '0;
      soft_err_cnt <= '0;
      pma_init     <= 1'b1;
      reset_pb     <= 1'b1;
      link_ok      <= 1'b0;
    end else begin
      state <= next_state;
      // Phase counter restarts on every state change and idles at 0 while disabled.
      if (next_state != state || (state == ASSERT_PMA && !link_en)) begin
        phase_cnt <= '0;
      end else if (state == ASSERT_PMA || state == RELEASE_PMA) begin
        phase_cnt <= phase_cnt + PH_W'(1);
      end
      tmo_cnt    <= (next_state == WAIT_UP) ? tmo_next : '0;
      stable_cnt <= (next_state == WAIT_UP) ? stable_next : '0;

      soft_d <= soft_s;
      if (state == LINK_UP && soft_s && !soft_d)
        soft_err_cnt <= CNT_W'(sat_inc(32'(soft_err_cnt), CNT_MAX));
      if (retry_inc) retry_cnt <= CNT_W'(sat_inc(32'(retry_cnt), CNT_MAX));
      if (drop_inc)  drop_cnt  <= CNT_W'(sat_inc(32'(drop_cnt), CNT_MAX));

      pma_init <= (next_state == ASSERT_PMA);
      reset_pb <= (next_state == ASSERT_PMA) || (next_state == RELEASE_PMA);
      link_ok  <= (next_state == LINK_UP);
    end
  end

endmodule

// File: tb/tb_aurora_link_sequencer.sv
// Directed bench for aurora_link_sequencer with a cycle-level reference model.
module tb_aurora_link_sequencer;

  localparam int NL   = 2;
  localparam int PMA  = 8;
  localparam int RPB  = 4;
  localparam int TMO  = 50;
  localparam int STB  = 5;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int VW   = 6 + 3 * CW;

  logic          sysclk = 1'b0;
  logic          reset, link_en, channel_up, hard_err, soft_err;
  logic [NL-1:0] lane_up;
  logic          pma_init, reset_pb, link_ok;
  logic [CW-1:0] retry_cnt, drop_cnt, soft_err_cnt;
  logic [2:0]    state_o;

  aurora_link_sequencer #(
    .NUM_LANES(NL), .PMA_INIT_CYCLES(PMA), .RESET_PB_CYCLES(RPB),
    .UP_TIMEOUT_CYCLES(TMO), .STABLE_CYCLES(STB), .CNT_W(CW)
  ) dut (
    .sysclk(sysclk), .reset(reset), .link_en(link_en), .channel_up(channel_up),
    .lane_up(lane_up), .hard_err(hard_err), .soft_err(soft_err),
    .pma_init(pma_init), .reset_pb(reset_pb), .link_ok(link_ok),
    .retry_cnt(retry_cnt), .drop_cnt(drop_cnt), .soft_err_cnt(soft_err_cnt),
    .state_o(state_o)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit saw_link = 1'b0;

  // Reference model: state name, cycles spent in state, current run of up_all cycles.
  int m_state, m_tis, m_run, m_retry, m_drop, m_soft;
  bit m_soft_prev;
  bit ms1_cu, ms2_cu, ms1_hard, ms2_hard, ms1_soft, ms2_soft;
  logic [NL-1:0] ms1_lane, ms2_lane;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_tis = 0; m_run = 0;
    m_retry = 0; m_drop = 0; m_soft = 0; m_soft_prev = 0;
    ms1_cu = 0; ms2_cu = 0; ms1_hard = 0; ms2_hard = 0; ms1_soft = 0; ms2_soft = 0;
    ms1_lane = '0; ms2_lane = '0;
  endtask

  task automatic go(input int s);
    m_state = s; m_tis = 0; m_run = 0;
  endtask

  task automatic model_step();
    bit up;
    if (reset) begin
      model_reset();
      return;
    end
    up = ms2_cu && (ms2_lane == {NL{1'b1}});
    if (m_state == 3 && ms2_soft && !m_soft_prev) m_soft = sat(m_soft);
    m_soft_prev = ms2_soft;
    if (!link_en) begin
      if (m_state == 3) m_drop = sat(m_drop);
      go(0);
    end else begin
      case (m_state)
        0: begin m_tis++; if (m_tis == PMA) go(1); end
        1: begin m_tis++; if (m_tis == RPB) go(2); end
        2: begin
          m_tis++;
          m_run = up ? m_run + 1 : 0;
          if (m_run == STB) go(3);
          else if (m_tis == TMO) begin m_retry = sat(m_retry); go(0); end
        end
        default: if (!up || ms2_hard) begin m_drop = sat(m_drop); go(0); end
      endcase
    end
    ms2_cu = ms1_cu; ms2_lane = ms1_lane; ms2_hard = ms1_hard; ms2_soft = ms1_soft;
    ms1_cu = channel_up; ms1_lane = lane_up; ms1_hard = hard_err; ms1_soft = soft_err;
  endtask

  function automatic logic [VW-1:0] model_vec();
    return {m_state == 0, m_state <= 1, m_state == 3, 3'(m_state),
            CW'(m_retry), CW'(m_drop), CW'(m_soft)};
  endfunction

  always @(negedge sysclk) begin
    if (chk_en) begin
      n_checks++;
      if ({pma_init, reset_pb, link_ok, state_o, retry_cnt, drop_cnt, soft_err_cnt} === model_vec())
        n_pass++;
      else
        $display("FAIL model_cmp t=%0t got=%h expected=%h", $time,
                 {pma_init, reset_pb, link_ok, state_o, retry_cnt, drop_cnt, soft_err_cnt}, model_vec());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      model_step();
      @(negedge sysclk);
      saw_link |= link_ok;
    end
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    model_reset();
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; link_en = 1'b1; channel_up = 1'b0; lane_up = '0;
    hard_err = 1'b0; soft_err = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_pma_init", pma_init, 1);
    check("rst_reset_pb", reset_pb, 1);
    check("rst_link_ok", link_ok, 0);
    check("rst_state", state_o, 0);
    tick(2);
    reset = 1'b0;

    // Nominal bring-up
    tick(PMA);
    check("nom_pma_low", pma_init, 0);
    check("nom_rpb_still_high", reset_pb, 1);
    tick(RPB);
    check("nom_rpb_low", reset_pb, 0);
    check("nom_state_wait", state_o, 2);
    tick(10);
    channel_up = 1'b1; lane_up = 2'b11;
    tick(6);
    check("nom_link_not_yet", link_ok, 0);
    tick(1);
    check("nom_link_ok", link_ok, 1);
    check("nom_retry", retry_cnt, 0);

    // Single-cycle channel drop
    channel_up = 1'b0; tick(1); channel_up = 1'b1;
    tick(1);
    check("drop_link_held", link_ok, 1);
    tick(1);
    check("drop_link_off", link_ok, 0);
    check("drop_pma", pma_init, 1);
    check("drop_cnt1", drop_cnt, 1);
    tick(16);
    check("resq_not_yet", link_ok, 0);
    tick(1);
    check("resq_link_ok", link_ok, 1);

    // Soft errors, then hard error coincident with channel loss
    for (int i = 0; i < 3; i++) begin
      soft_err = 1'b1; tick(1); soft_err = 1'b0; tick(2);
    end
    tick(3);
    check("soft_cnt3", soft_err_cnt, 3);
    check("soft_link_kept", link_ok, 1);
    hard_err = 1'b1; channel_up = 1'b0;
    tick(3);
    check("hard_drop_cnt", drop_cnt, 2);
    check("hard_link_off", link_ok, 0);
    hard_err = 1'b0;
    tick(3);
    check("hard_single_drop", drop_cnt, 2);

    // Async reset in the middle of WAIT_UP
    tick(14);
    check("pre_rst_wait", state_o, 2);
    @(posedge sysclk);
    model_step();
    #2 reset = 1'b1;
    #1;
    check("arst_pma", pma_init, 1);
    check("arst_rpb", reset_pb, 1);
    check("arst_drop", drop_cnt, 0);
    check("arst_soft", soft_err_cnt, 0);
    check("arst_state", state_o, 0);
    model_reset();
    link_en = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(100);
    check("dis_state", state_o, 0);
    check("dis_pma", pma_init, 1);
    link_en = 1'b1;
    tick(PMA - 1);
    check("en_pma_still", pma_init, 1);
    tick(1);
    check("en_pma_low", pma_init, 0);

    // Timeout retries with one lane down, saturating retry count
    do_reset();
    channel_up = 1'b1; lane_up = 2'b01; saw_link = 1'b0;
    tick(62);
    check("tmo_retry1", retry_cnt, 1);
    tick(123);
    check("tmo_retry2", retry_cnt, 2);
    tick(1);
    check("tmo_retry3", retry_cnt, 3);
    check("tmo_state", state_o, 0);
    tick(62);
    check("tmo_retry_sat", retry_cnt, 3);
    check("tmo_never_link", saw_link, 0);

    // Flickering link never reaches the stable threshold
    do_reset();
    channel_up = 1'b1; saw_link = 1'b0;
    for (int i = 0; i < 62; i++) begin
      lane_up = ((i / 3) % 2 == 0) ? 2'b11 : 2'b00;
      tick(1);
      if (i == 60) check("flk_retry0", retry_cnt, 0);
    end
    check("flk_retry1", retry_cnt, 1);
    check("flk_state", state_o, 0);
    check("flk_never_link", saw_link, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
